switch_debouncer: RTL
=====================

// Module: switch_debouncer
// PURPOSE
//  Conditions a raw, asynchronous, bouncing switch/button level into a clean, stable,
//  clk-synchronous level. It sits directly upstream of the D flip-flop stage and drives
//  its d input. It also emits single-cycle rise/fall strobes for downstream control logic.
// PARAMETERS
//  SYNC_STAGES    2   synchroniser depth on din_raw; legal range >= 2
//  STABLE_CYCLES  4   consecutive synchronised samples at the new level needed to accept it;
//                     legal range >= 2
//  CNT_W          $clog2(STABLE_CYCLES)+1   width of the stability counter (localparam)
// PORTS
//  clk         in   1      rising-edge clock; the only clock
//  rst         in   1      reset, synchronous, active-high
//  din_raw     in   1      raw asynchronous switch level
//  dout        out  1      debounced level; feeds the flip-flop's d input
//  rise_pulse  out  1      1-cycle strobe when dout goes 0->1
//  fall_pulse  out  1      1-cycle strobe when dout goes 1->0
//  evt_cnt     out  8      accepted rising transitions; present only with DEBOUNCE_EVT_CNT_EN
// BEHAVIOUR
//  - Synchroniser: SYNC_STAGES-deep FF chain on din_raw; its last stage is "sync".
//  - FSM states: IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO.
//    IDLE_LO: sync==1 -> WAIT_HI, cnt<=1; otherwise hold.
//    WAIT_HI: sync==0 -> IDLE_LO, cnt<=0 (bounce rejected).
//             sync==1 and cnt==STABLE_CYCLES-1 -> IDLE_HI, dout<=1, rise_pulse<=1, cnt<=0.
//             sync==1 otherwise -> cnt<=cnt+1.
//    IDLE_HI / WAIT_LO: mirror images, with sync==0 and fall_pulse.
//  - Latency: k = first clk edge that samples a new din_raw level. If din_raw holds that
//    level, dout changes at edge k+SYNC_STAGES+STABLE_CYCLES-1 (defaults: k+5).
//  - Any excursion shorter than STABLE_CYCLES synchronised samples never changes dout and
//    never pulses.
//  - rise_pulse and fall_pulse are registered, are high for exactly 1 cycle, and are
//    never high together.
//  - dout changes only on an accepted transition. All outputs are registered.
//  - Reset: all synchroniser FFs, dout, rise_pulse, fall_pulse and evt_cnt go to 0;
//    state<=IDLE_LO; cnt<=0. Reset overrides any same-edge transition.
//  - Reset mid-WAIT discards all progress. If din_raw is already high after reset, the
//    full latency applies again before dout rises.
// CONFIGURATION
//  - `DEBOUNCE_EVT_CNT_EN defined: the evt_cnt port and its 8-bit register exist.
//    evt_cnt increments in the same cycle rise_pulse is asserted and wraps 255->0.
//  - `DEBOUNCE_EVT_CNT_EN undefined: the evt_cnt port and its logic are absent. All other
//    behaviour is identical.
// STRUCTURE
//  - Shared package/header debounce_pkg: FSM state encodings (IDLE_LO=2'd0, WAIT_HI=2'd1,
//    IDLE_HI=2'd2, WAIT_LO=2'd3) and EVT_CNT_W=8.
//  - One sub-module: sync_ff_chain (parameter STAGES; ports clk, rst, d, q). The top holds
//    the FSM, counter and pulse/event registers.
// TESTING (clk period 10ns, default parameters)
//  1. rst=1 for 2 cycles, din_raw=0 -> dout=0, rise_pulse=0, fall_pulse=0, evt_cnt=0.
//  2. din_raw 0->1 held; first sampling edge k -> dout=1 at edge k+5, rise_pulse=1 for
//     exactly that one cycle, evt_cnt=1.
//  3. With dout=1, din_raw bounces 1,0,1,0 (1 cycle each), then settles at 0 -> dout stays
//     1 through the bounces and falls 5 edges after the last settling edge; fall_pulse=1
//     for 1 cycle.
//  4. Glitches of 1, 2 and 3 cycles high while dout=0 -> dout, rise_pulse and evt_cnt
//     unchanged.
//  5. rst asserted 2 cycles into WAIT_HI with din_raw held high -> dout stays 0. After rst
//     drops, dout rises 5 edges after the first post-reset sampling edge.
//  6. (EN build) 257 accepted rising transitions -> evt_cnt reads 1 (wrap verified);
//     rise_pulse and fall_pulse never both high.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the switch debouncer: FSM state encodings and event counter width.
package debounce_pkg;

   typedef enum logic [1:0] {
      IDLE_LO = 2'd0,
      WAIT_HI = 2'd1,
      IDLE_HI = 2'd2,
      WAIT_LO = 2'd3
   } state_e;

   localparam int EVT_CNT_W = 8;

endpackage

// File: rtl/sync_ff_chain.sv
// STAGES-deep flip-flop chain that brings an asynchronous level into the clk domain.
module sync_ff_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         chain_q <= '0;
      end else begin
         chain_q <= {chain_q[STAGES-2:0], d};
      end
   end

   assign q = chain_q[STAGES-1];

endmodule

// File: rtl/switch_debouncer.sv
// Debounces a raw switch level into a clean clk-synchronous level with rise/fall strobes.
// Define DEBOUNCE_EVT_CNT_EN to add the 8-bit evt_cnt port counting accepted rising edges.
module switch_debouncer
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic din_raw,
   output logic dout,
   output logic rise_pulse,
   output logic fall_pulse
`ifdef DEBOUNCE_EVT_CNT_EN
   ,
   output logic [EVT_CNT_W-1:0] evt_cnt
`endif
);

   localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             syncLevel;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dout_q, dout_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   sync_ff_chain #(
      .STAGES(SYNC_STAGES)
   ) u_sync (
      .clk(clk),
      .rst(rst),
      .d  (din_raw),
      .q  (syncLevel)
   );

   // cnt counts consecutive synchronised samples at the candidate level, including the first.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         IDLE_LO: begin
            if (syncLevel) begin
               state_d = WAIT_HI;
               cnt_d   = CNT_ONE;
            end
         end
         WAIT_HI: begin
            if (!syncLevel) begin
               state_d = IDLE_LO;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_HI;
               dout_d  = 1'b1;
               rise_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         IDLE_HI: begin
            if (!syncLevel) begin
               state_d = WAIT_LO;
               cnt_d   = CNT_ONE;
            end
         end
         WAIT_LO: begin
            if (syncLevel) begin
               state_d = IDLE_HI;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_LO;
               dout_d  = 1'b0;
               fall_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE_LO;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE_LO;
         cnt_q   <= '0;
         dout_q  <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign dout       = dout_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;

`ifdef DEBOUNCE_EVT_CNT_EN
   logic [EVT_CNT_W-1:0] evtCnt_q;

   // Advances on the same edge that raises rise_pulse; wraps naturally at 255.
   always_ff @(posedge clk) begin
      if (rst) begin
         evtCnt_q <= '0;
      end else if (rise_d) begin
         evtCnt_q <= evtCnt_q + EVT_CNT_W'(1);
      end
   end

   assign evt_cnt = evtCnt_q;
`else
   // No event counter in this build.
`endif

endmodule
